// File: rtl/antilog2_pkg.sv
// Shared defaults, stage-1 payload type and a behavioural reference for the
// base-2 antilog pipeline (Mitchell linear mantissa).
// Optional build macro: ANTILOG2_ROUND_EN (round-half-up when e < FRAC_W).
package antilog2_pkg;

    localparam int ANTILOG2_D_W    = 32;
    localparam int ANTILOG2_FRAC_W = 8;
    localparam int ANTILOG2_INT_W  = $clog2(ANTILOG2_D_W);

    // Stage-1 payload at the default widths: exponent, mantissa with hidden one, row end.
    typedef struct packed {
        logic [ANTILOG2_INT_W-1:0]  e;
        logic [ANTILOG2_FRAC_W:0]   m;
        logic                       last;
    } stage1_t;

    // Arithmetic reference: floor(({1,f} << e) / 2^FRAC_W), optionally adding
    // half an LSB first when the shift leaves fractional bits behind.
    function automatic logic [ANTILOG2_D_W-1:0] antilog2_ref(
        input logic [ANTILOG2_INT_W-1:0]  e,
        input logic [ANTILOG2_FRAC_W-1:0] f,
        input logic                       round
    );
        logic [63:0] p;
        p = (64'(1) << ANTILOG2_FRAC_W) | 64'(f);
        p = p << e;
        if (round && (int'(e) < ANTILOG2_FRAC_W))
            p = p + (64'(1) << (ANTILOG2_FRAC_W - 1));
        return ANTILOG2_D_W'(p >> ANTILOG2_FRAC_W);
    endfunction

endpackage

// File: rtl/antilog2_shift.sv
// Combinational barrel shift of the mantissa by the exponent, followed by
// truncation (or round-half-up when ANTILOG2_ROUND_EN is defined).
module antilog2_shift
    import antilog2_pkg::*;
#(
    parameter int  D_W    = ANTILOG2_D_W,
    parameter int  FRAC_W = ANTILOG2_FRAC_W,
    localparam int INT_W  = $clog2(D_W)
)(
    input  logic [INT_W-1:0]  e,
    input  logic [FRAC_W:0]   m,
    output logic [D_W-1:0]    y
);

    localparam int P_W = D_W + FRAC_W + 1;

    // stg[k] holds the mantissa shifted by the low k exponent bits.
    logic [P_W-1:0] stg [INT_W+1];
    logic [P_W-1:0] p_final;
    logic           unused_bits;

    assign stg[0] = P_W'(m);

    genvar gi;
    generate
        for (gi = 0; gi < INT_W; gi++) begin : g_shift
            assign stg[gi+1] = e[gi] ? (stg[gi] << (2**gi)) : stg[gi];
        end
    endgenerate

`ifdef ANTILOG2_ROUND_EN
    localparam logic [INT_W-1:0] FRAC_E = INT_W'(FRAC_W);
    localparam logic [P_W-1:0]   HALF   = P_W'(1) << (FRAC_W - 1);
    // Only shifts shorter than FRAC_W discard fractional bits; larger ones are exact.
    assign p_final = (e < FRAC_E) ? (stg[INT_W] + HALF) : stg[INT_W];
`else
    assign p_final = stg[INT_W];
`endif

    assign y = p_final[D_W+FRAC_W-1:FRAC_W];

    // Dropped fractional bits and the always-zero top bit.
    assign unused_bits = ^{p_final[P_W-1], p_final[FRAC_W-1:0]};

endmodule

// File: rtl/antilog2.sv
// Two-stage valid/ready base-2 antilog: stage 1 captures {e, 1.f, last},
// stage 2 shifts/truncates and presents the result. Full backpressure,
// bubbles collapse. Optional build macro: ANTILOG2_ROUND_EN.
module antilog2
    import antilog2_pkg::*;
#(
    parameter int  D_W    = ANTILOG2_D_W,
    parameter int  FRAC_W = ANTILOG2_FRAC_W,
    localparam int INT_W  = $clog2(D_W)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [INT_W+FRAC_W-1:0] s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [D_W-1:0]          m_data,
    output logic                    m_last
);

    // Same layout as stage1_t, but sized from this instance's parameters.
    typedef struct packed {
        logic [INT_W-1:0] e;
        logic [FRAC_W:0]  m;
        logic             last;
    } payload_t;

    payload_t       stage1_reg;
    logic           stage1_valid;
    logic           stage2_valid;
    logic           rst_done;
    logic           rdy1;
    logic           rdy2;
    logic           accept;
    logic [D_W-1:0] shift_y;

    assign rdy2    = !stage2_valid || m_ready;
    assign rdy1    = !stage1_valid || rdy2;
    assign s_ready = rdy1 && rst_done;
    assign accept  = s_valid && s_ready;
    assign m_valid = stage2_valid;

    // Hold off input acceptance until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    // Stage 1: capture exponent, mantissa with hidden one, and row-end flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_valid <= 1'b0;
            stage1_reg   <= '0;
        end else if (rdy1) begin
            stage1_valid <= accept;
            if (accept) begin
                stage1_reg.e    <= s_data[INT_W+FRAC_W-1:FRAC_W];
                stage1_reg.m    <= {1'b1, s_data[FRAC_W-1:0]};
                stage1_reg.last <= s_last;
            end
        end
    end

    antilog2_shift #(
        .D_W    (D_W),
        .FRAC_W (FRAC_W)
    ) u_shift (
        .e (stage1_reg.e),
        .m (stage1_reg.m),
        .y (shift_y)
    );

    // Stage 2: register the shifted result; held while stalled downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage2_valid <= 1'b0;
            m_data       <= '0;
            m_last       <= 1'b0;
        end else if (rdy2) begin
            stage2_valid <= stage1_valid;
            if (stage1_valid) begin
                m_data <= shift_y;
                m_last <= stage1_reg.last;
            end
        end
    end

endmodule
